// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - message ids, letter codes, lengths and glyph geometry for the message sequencer
package msg_pkg;

  localparam int GLYPH       = 50;
  localparam int GLYPH_SQ    = GLYPH * GLYPH;
  localparam int MSG_ROW     = 190;
  localparam int MSG_COL     = 170;
  localparam int MAX_CHARS   = 8;
  localparam int HOLD_FRAMES = 120;
  localparam int ADDR_W      = 16;
  localparam int CHAR_W      = $clog2(MAX_CHARS + 1);

  typedef enum logic [1:0] {
    MSG_NONE   = 2'd0,
    MSG_READY  = 2'd1,
    MSG_WAND   = 2'd2,
    MSG_TIMEUP = 2'd3
  } msg_e;

  typedef enum logic [4:0] {
    L_A, L_B, L_C, L_D, L_E, L_F, L_G, L_H, L_I, L_J, L_K, L_L, L_M,
    L_N, L_O, L_P, L_Q, L_R, L_S, L_T, L_U, L_V, L_W, L_X, L_Y, L_Z,
    L_SPACE
  } letter_e;

  localparam logic [CHAR_W-1:0] LEN_NONE   = CHAR_W'(0);
  localparam logic [CHAR_W-1:0] LEN_READY  = CHAR_W'(5);
  localparam logic [CHAR_W-1:0] LEN_WAND   = CHAR_W'(4);
  localparam logic [CHAR_W-1:0] LEN_TIMEUP = CHAR_W'(8);

  function automatic logic [CHAR_W-1:0] msg_len(msg_e m);
    case (m)
      MSG_READY:  msg_len = LEN_READY;
      MSG_WAND:   msg_len = LEN_WAND;
      MSG_TIMEUP: msg_len = LEN_TIMEUP;
      default:    msg_len = LEN_NONE;
    endcase
  endfunction

  // Out-of-range indices return SPACE so they can never reach the ROM
  function automatic letter_e msg_code(msg_e m, logic [CHAR_W-1:0] idx);
    msg_code = L_SPACE;
    case (m)
      MSG_READY: begin
        case (idx)
          4'd0: msg_code = L_R;
          4'd1: msg_code = L_E;
          4'd2: msg_code = L_A;
          4'd3: msg_code = L_D;
          4'd4: msg_code = L_Y;
          default: msg_code = L_SPACE;
        endcase
      end
      MSG_WAND: begin
        case (idx)
          4'd0: msg_code = L_W;
          4'd1: msg_code = L_A;
          4'd2: msg_code = L_N;
          4'd3: msg_code = L_D;
          default: msg_code = L_SPACE;
        endcase
      end
      MSG_TIMEUP: begin
        case (idx)
          4'd0: msg_code = L_T;
          4'd1: msg_code = L_I;
          4'd2: msg_code = L_M;
          4'd3: msg_code = L_E;
          4'd4: msg_code = L_S;
          4'd5: msg_code = L_SPACE;
          4'd6: msg_code = L_U;
          4'd7: msg_code = L_P;
          default: msg_code = L_SPACE;
        endcase
      end
      default: msg_code = L_SPACE;
    endcase
  endfunction

endpackage

// File: rtl/glyph_addr_gen.sv
// rtl/glyph_addr_gen.sv - message window test, glyph pixel counters and letter ROM address
module glyph_addr_gen
  import msg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        row,
  input  logic [9:0]        col,
  input  msg_e              msg,
  output logic [ADDR_W-1:0] glyph_addr,
  output logic              glyph_en
);

  logic [9:0]        col_end;
  logic              in_win;
  logic [5:0]        px;
  logic [5:0]        px_q;
  logic [5:0]        py;
  logic [CHAR_W-1:0] char_idx;
  logic [CHAR_W-1:0] char_q;
  letter_e           code;
  logic [ADDR_W-1:0] addr_next;

  // Window test and current cell position; counters restart at the window's left edge
  always_comb begin
    col_end   = 10'(MSG_COL) + 10'(msg_len(msg)) * 10'(GLYPH);
    in_win    = (row >= 9'(MSG_ROW)) && (row < 9'(MSG_ROW + GLYPH)) &&
                (col >= 10'(MSG_COL)) && (col < col_end);
    px        = (col == 10'(MSG_COL)) ? 6'd0 : px_q;
    char_idx  = (col == 10'(MSG_COL)) ? '0 : char_q;
    py        = in_win ? 6'(row - 9'(MSG_ROW)) : 6'd0;
    code      = msg_code(msg, char_idx);
    addr_next = ADDR_W'(code) * ADDR_W'(GLYPH_SQ) + ADDR_W'(py) * ADDR_W'(GLYPH) + ADDR_W'(px);
  end

  // Advance counters inside the window and register the address; SPACE cells keep the old address
  always_ff @(posedge clk) begin
    if (reset) begin
      px_q       <= 6'd0;
      char_q     <= '0;
      glyph_addr <= '0;
      glyph_en   <= 1'b0;
    end else begin
      glyph_en <= 1'b0;
      if (in_win) begin
        if (px == 6'(GLYPH - 1)) begin
          px_q   <= 6'd0;
          char_q <= char_idx + 1'b1;
        end else begin
          px_q   <= px + 6'd1;
          char_q <= char_idx;
        end
        if (code != L_SPACE) begin
          glyph_en   <= 1'b1;
          glyph_addr <= addr_next;
        end
      end
    end
  end

endmodule

// File: rtl/message_sequencer.sv
// rtl/message_sequencer.sv - game-event driven message selection with frame-aligned switching
module message_sequencer
  import msg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        row,
  input  logic [9:0]        col,
  input  logic              game_start,
  input  logic              countdown_done,
  input  logic              time_expired,
  output logic [ADDR_W-1:0] glyph_addr,
  output logic              glyph_en,
  output logic [1:0]        msg_id,
  output logic              msg_busy
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES);

  msg_e              state, state_next;
  logic              pend_valid, pend_valid_next;
  msg_e              pend_msg, pend_msg_next;
  logic [1:0]        pend_prio, pend_prio_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic              ev_valid;
  msg_e              ev_msg;
  logic [1:0]        ev_prio;
  logic              frame_tick;
  logic              hold_expired;
  logic              advance;

  assign frame_tick   = (row == 9'd0) && (col == 10'd0);
  assign hold_expired = (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));

  // Highest-priority event this cycle that applies to the message on screen
  always_comb begin
    ev_valid = 1'b0;
    ev_msg   = MSG_NONE;
    ev_prio  = 2'd0;
    if (time_expired) begin
      ev_valid = 1'b1;
      ev_msg   = MSG_TIMEUP;
      ev_prio  = 2'd3;
    end else if (game_start) begin
      ev_valid = 1'b1;
      ev_msg   = MSG_READY;
      ev_prio  = 2'd2;
    end else if (countdown_done && state == MSG_READY) begin
      ev_valid = 1'b1;
      ev_msg   = MSG_WAND;
      ev_prio  = 2'd1;
    end
  end

  // Pending merge, frame-aligned message switch and hold timer update
  always_comb begin
    pend_valid_next = pend_valid;
    pend_msg_next   = pend_msg;
    pend_prio_next  = pend_prio;
    state_next      = state;
    hold_cnt_next   = hold_cnt;
    advance         = 1'b0;
    if (ev_valid && (!pend_valid || ev_prio >= pend_prio)) begin
      pend_valid_next = 1'b1;
      pend_msg_next   = ev_msg;
      pend_prio_next  = ev_prio;
    end
    if (frame_tick) begin
      if (pend_valid_next) begin
        state_next = pend_msg_next;
        advance    = 1'b1;
      end else if (hold_expired && state == MSG_READY) begin
        state_next = MSG_WAND;
        advance    = 1'b1;
      end else if (hold_expired && state == MSG_WAND) begin
        state_next = MSG_NONE;
        advance    = 1'b1;
      end
      pend_valid_next = 1'b0;
      if (advance) begin
        hold_cnt_next = '0;
      end else if (!hold_expired) begin
        hold_cnt_next = hold_cnt + 1'b1;
      end
    end
  end

  // State, pending event and hold timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MSG_NONE;
      pend_valid <= 1'b0;
      pend_msg   <= MSG_NONE;
      pend_prio  <= 2'd0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_next;
      pend_valid <= pend_valid_next;
      pend_msg   <= pend_msg_next;
      pend_prio  <= pend_prio_next;
      hold_cnt   <= hold_cnt_next;
    end
  end

  assign msg_id   = state;
  assign msg_busy = (state != MSG_NONE);

  glyph_addr_gen u_glyph_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .row        (row),
    .col        (col),
    .msg        (state),
    .glyph_addr (glyph_addr),
    .glyph_en   (glyph_en)
  );

endmodule

// File: doc/message_sequencer.md
Name: message_sequencer

Overview:
Sequences the on-screen text messages ("READY", "WAND", "TIMES UP") over a game session and drives the shared 50x50 glyph letter ROM for the message window. Sits between game-state logic and the letters ROM. Game events select which message is shown and for how long. Per-pixel row/col scan positions are converted into glyph ROM addresses with counters rather than modulo arithmetic.

Parameters:
GLYPH, 50, glyph edge in pixels (one ROM glyph = GLYPH*GLYPH words)
MSG_ROW, 190, first scan row of the message window
MSG_COL, 170, first scan column of the message window
MAX_CHARS, 8, longest message length in characters
HOLD_FRAMES, 120, frames a timed message stays visible
ADDR_W, 16, glyph ROM address width

Ports:
clk  in  1  pixel clock, all logic on posedge
reset  in  1  synchronous, active-high
row  in  9  current scan row
col  in  10  current scan column
game_start  in  1  one-cycle pulse: new round begins
countdown_done  in  1  one-cycle pulse: pre-round countdown finished
time_expired  in  1  one-cycle pulse: round timer hit zero
glyph_addr  out  ADDR_W  letters ROM address, registered
glyph_en  out  1  pixel is inside a visible, non-space glyph cell, registered
msg_id  out  2  current message: 0 NONE, 1 READY, 2 WAND, 3 TIMEUP
msg_busy  out  1  high while msg_id != NONE

Behaviour:
- Reset: msg_id=NONE, msg_busy=0, glyph_addr=0, glyph_en=0, pending cleared, frame counter=0, pixel counters=0.
- frame_tick = (row==0 && col==0), evaluated combinationally from the inputs.
- Event capture: every event pulse is latched into a pending next-message register on the cycle it arrives. Priority when events coincide in one cycle: time_expired > game_start > countdown_done. A later higher-priority event overwrites a pending lower-priority one. A lower-priority event never overwrites a pending higher-priority one.
- msg_id changes only on frame_tick, so a message never tears mid-frame.
- FSM transitions:
  - NONE: game_start -> READY.
  - READY: countdown_done -> WAND; hold timer expiry -> WAND.
  - WAND: hold timer expiry -> NONE.
  - TIMEUP: holds indefinitely, exits only via game_start -> READY.
  - From any state: time_expired -> TIMEUP. game_start from READY or WAND restarts READY.
  - Events that do not apply to the current state are dropped and do not set pending.
- Hold timer: counts frame_ticks and is cleared on every msg_id change. Expiry occurs on the frame_tick where the count reaches HOLD_FRAMES-1, so a timed message is displayed for exactly HOLD_FRAMES frames. The counter saturates and never wraps.
- Message table (letter codes A=0..Z=25, SPACE=26):
  - READY = R,E,A,D,Y
  - WAND = W,A,N,D
  - TIMEUP = T,I,M,E,S,SPACE,U,P
  - NONE has length 0.
- Window:
  - Rows: MSG_ROW <= row < MSG_ROW+GLYPH.
  - Cols: MSG_COL <= col < MSG_COL+len*GLYPH, where len is the length of the current message.
- Pixel counters:
  - px resets to 0 at col==MSG_COL, increments each in-window cycle, and wraps 49->0.
  - char_idx increments on each px wrap.
  - py = row-MSG_ROW; the only subtraction allowed is on row, and only inside the window.
- Address: glyph_addr = code*GLYPH*GLYPH + py*GLYPH + px, registered, one-cycle latency from row/col. The maximum value 26*2500+2499 = 67499 exceeds 16 bits, so SPACE must never be addressed. For SPACE cells and outside the window: glyph_en=0 and glyph_addr holds its last value.
- Reset mid-frame: outputs are cleared on the next edge, and the message restarts at NONE.

Decomposition:
- msg_pkg:
  - message id constants
  - letter code constants (A..Z, SPACE)
  - per-message length constants
  - message-to-code lookup function
  - GLYPH-derived constants
- Sub-module glyph_addr_gen: window test, px/char_idx counters and address multiply-add. The FSM, event capture and hold timer stay in the top-level module.

Test Plan:
- Reset, then game_start pulse at row 5 -> msg_id stays 0 until the next (0,0) tick, then becomes 1; at row=190,col=170 one cycle later, glyph_addr=17*2500=42500 and glyph_en=1.
- READY active, no countdown_done -> msg_id becomes 2 after exactly 120 frame_ticks; WAND then returns to 0 after 120 more.
- Same cycle time_expired and game_start -> next tick msg_id=3; further countdown_done is ignored; a later game_start -> 1.
- TIMEUP, scan row 200, col 420..469 (6th char, SPACE) -> glyph_en=0; col 470 -> glyph_addr=20*2500+10*50+0=50500.
- WAND active, col 370 (past 4 chars) -> glyph_en=0; col 369,row 239 -> glyph_addr=3*2500+49*50+49=9999.
- reset asserted mid-window during READY -> next cycle glyph_en=0, msg_id=0, msg_busy=0.
